// File: rtl/video_mode_detect.sv
// Classifies Dreamcast capture geometry (480p/240p/480i) from counterX/counterY wraps, with hysteresis and signal-loss timeout.
// Latency: mode/valid/changed update 2 clocks after the field wrap; no backpressure, inputs sampled every clock.
module video_mode_detect #(
   parameter int STABLE_FIELDS  = 4,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int LINE_TOL       = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] counterX,
   input  logic [11:0] counterY,
   output logic [1:0]  mode,
   output logic        mode_valid,
   output logic        mode_changed,
   output logic [11:0] field_lines,
   output logic [11:0] line_pixels
);

   localparam int SW = $clog2(STABLE_FIELDS + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [SW-1:0] STABLE_N = SW'(STABLE_FIELDS);
   localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [11:0]   P_LO     = 12'(525 - LINE_TOL);
   localparam logic [11:0]   P_HI     = 12'(525 + LINE_TOL);
   localparam logic [11:0]   I_LO     = 12'd261;
   localparam logic [11:0]   I_HI     = 12'd264;

   localparam logic [1:0] MODE_NONE = 2'd0;
   localparam logic [1:0] MODE_480P = 2'd1;
   localparam logic [1:0] MODE_240P = 2'd2;
   localparam logic [1:0] MODE_480I = 2'd3;

   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED, LOST} state_t;

   state_t        state_q, state_d;
   logic [11:0]   prev_x_q, prev_x_d;
   logic [11:0]   prev_y_q, prev_y_d;
   logic [11:0]   cur_pixels_q, cur_pixels_d;
   logic [11:0]   meas_lines_q, meas_lines_d;
   logic [11:0]   meas_pixels_q, meas_pixels_d;
   logic [11:0]   last_lines_q, last_lines_d;
   logic          meas_vld_q, meas_vld_d;
   logic [TW-1:0] timeout_cnt_q, timeout_cnt_d;
   logic [1:0]    cand_q, cand_d;
   logic [SW-1:0] stable_cnt_q, stable_cnt_d;
   logic [1:0]    mode_q, mode_d;
   logic          mode_changed_q, mode_changed_d;
   logic [11:0]   field_lines_q, field_lines_d;
   logic [11:0]   line_pixels_q, line_pixels_d;

   logic          line_wrap;
   logic          field_wrap;
   logic          timeout_hit;
   logic [1:0]    cls;

   assign line_wrap  = counterX < prev_x_q;
   assign field_wrap = counterY < prev_y_q;

   // Measurement pipeline; a coincident line wrap completes the last line before it is captured.
   always_comb begin
      prev_x_d      = counterX;
      prev_y_d      = counterY;
      cur_pixels_d  = line_wrap ? prev_x_q + 12'd1 : cur_pixels_q;
      meas_lines_d  = meas_lines_q;
      meas_pixels_d = meas_pixels_q;
      last_lines_d  = last_lines_q;
      meas_vld_d    = field_wrap;
      if (field_wrap) begin
         meas_lines_d  = prev_y_q + 12'd1;
         meas_pixels_d = cur_pixels_d;
         last_lines_d  = meas_lines_q;
      end
      if (field_wrap)
         timeout_cnt_d = '0;
      else if (timeout_cnt_q == TMAX)
         timeout_cnt_d = TMAX;
      else
         timeout_cnt_d = timeout_cnt_q + TW'(1);
   end

   always_comb begin
      cls = MODE_NONE;
      if (meas_lines_q >= P_LO && meas_lines_q <= P_HI)
         cls = MODE_480P;
      else if (meas_lines_q >= I_LO && meas_lines_q <= I_HI) begin
         if (meas_lines_q == last_lines_q)
            cls = MODE_240P;
         else if (meas_lines_q == last_lines_q + 12'd1 || last_lines_q == meas_lines_q + 12'd1)
            cls = MODE_480I;
      end
   end

   // A field wrap on the same clock as the timeout keeps the signal alive.
   assign timeout_hit = (timeout_cnt_q == TMAX) && !field_wrap && (state_q != LOST);

   always_comb begin
      state_d        = state_q;
      cand_d         = cand_q;
      stable_cnt_d   = stable_cnt_q;
      mode_d         = mode_q;
      mode_changed_d = 1'b0;
      field_lines_d  = field_lines_q;
      line_pixels_d  = line_pixels_q;
      if (timeout_hit) begin
         state_d        = LOST;
         mode_d         = MODE_NONE;
         field_lines_d  = '0;
         line_pixels_d  = '0;
         mode_changed_d = (mode_q != MODE_NONE);
      end else begin
         case (state_q)
            SEARCH: begin
               if (meas_vld_q) begin
                  state_d      = MEASURE;
                  cand_d       = MODE_NONE;
                  stable_cnt_d = '0;
               end
            end
            MEASURE: begin
               if (meas_vld_q) begin
                  if (cls == cand_q) begin
                     if (stable_cnt_q != STABLE_N)
                        stable_cnt_d = stable_cnt_q + SW'(1);
                  end else begin
                     cand_d       = cls;
                     stable_cnt_d = SW'(1);
                  end
                  if (stable_cnt_d >= STABLE_N && cand_d != MODE_NONE) begin
                     state_d        = LOCKED;
                     mode_d         = cand_d;
                     mode_changed_d = (cand_d != mode_q);
                     field_lines_d  = meas_lines_q;
                     line_pixels_d  = meas_pixels_q;
                  end
               end
            end
            LOCKED: begin
               if (meas_vld_q) begin
                  field_lines_d = meas_lines_q;
                  line_pixels_d = meas_pixels_q;
                  if (cls != mode_q) begin
                     state_d      = MEASURE;
                     cand_d       = cls;
                     stable_cnt_d = SW'(1);
                  end
               end
            end
            default: state_d = SEARCH;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state_q <= SEARCH;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev_x_q       <= '0;
         prev_y_q       <= '0;
         cur_pixels_q   <= '0;
         meas_lines_q   <= '0;
         meas_pixels_q  <= '0;
         last_lines_q   <= '0;
         meas_vld_q     <= 1'b0;
         timeout_cnt_q  <= '0;
         cand_q         <= MODE_NONE;
         stable_cnt_q   <= '0;
         mode_q         <= MODE_NONE;
         mode_changed_q <= 1'b0;
         field_lines_q  <= '0;
         line_pixels_q  <= '0;
      end else begin
         prev_x_q       <= prev_x_d;
         prev_y_q       <= prev_y_d;
         cur_pixels_q   <= cur_pixels_d;
         meas_lines_q   <= meas_lines_d;
         meas_pixels_q  <= meas_pixels_d;
         last_lines_q   <= last_lines_d;
         meas_vld_q     <= meas_vld_d;
         timeout_cnt_q  <= timeout_cnt_d;
         cand_q         <= cand_d;
         stable_cnt_q   <= stable_cnt_d;
         mode_q         <= mode_d;
         mode_changed_q <= mode_changed_d;
         field_lines_q  <= field_lines_d;
         line_pixels_q  <= line_pixels_d;
      end
   end

   assign mode         = mode_q;
   assign mode_valid   = (state_q == LOCKED);
   assign mode_changed = mode_changed_q;
   assign field_lines  = field_lines_q;
   assign line_pixels  = line_pixels_q;

endmodule

// File: tb/tb_video_mode_detect.sv
// Directed bench for video_mode_detect: each line is two clocks (x=0 then x=857), so fields stay short.
// Timeout shortened to keep the loss scenario fast.
module tb_video_mode_detect;

   localparam int TO = 3000;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [11:0] counter_x = '0;
   logic [11:0] counter_y = '0;
   logic [1:0]  mode;
   logic        mode_valid;
   logic        mode_changed;
   logic [11:0] field_lines;
   logic [11:0] line_pixels;

   int n_checks  = 0;
   int n_fail    = 0;
   int pulse_cnt = 0;
   int p0        = 0;

   video_mode_detect #(
      .STABLE_FIELDS (4),
      .TIMEOUT_CYCLES(TO),
      .LINE_TOL      (2)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .counterX    (counter_x),
      .counterY    (counter_y),
      .mode        (mode),
      .mode_valid  (mode_valid),
      .mode_changed(mode_changed),
      .field_lines (field_lines),
      .line_pixels (line_pixels)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (mode_changed === 1'b1)
         pulse_cnt++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic gen_lines(input int first, input int last, input int px);
      for (int y = first; y < last; y++) begin
         counter_x = '0;
         counter_y = 12'(y);
         tick();
         counter_x = 12'(px - 1);
         tick();
      end
   endtask

   task automatic gen_field(input int lines);
      gen_lines(0, lines, 858);
   endtask

   task automatic apply_reset();
      reset     = 1'b1;
      counter_x = '0;
      counter_y = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #2;
      reset = 1'b1;
      #1;
      check_val("rst_mode",   32'(mode),         0);
      check_val("rst_valid",  32'(mode_valid),   0);
      check_val("rst_change", 32'(mode_changed), 0);
      check_val("rst_lines",  32'(field_lines),  0);
      check_val("rst_pixels", 32'(line_pixels),  0);
      tick();
      tick();
      reset = 1'b0;

      // 480p lock with latency check on the 5th wrap
      p0 = pulse_cnt;
      repeat (5) gen_field(525);
      check_val("p_pre_mode",  32'(mode),       0);
      check_val("p_pre_valid", 32'(mode_valid), 0);
      counter_x = '0;
      counter_y = '0;
      tick();
      check_val("p_lat1_mode", 32'(mode), 0);
      tick();
      check_val("p_mode",    32'(mode),         1);
      check_val("p_valid",   32'(mode_valid),   1);
      check_val("p_changed", 32'(mode_changed), 1);
      check_val("p_lines",   32'(field_lines),  525);
      check_val("p_pixels",  32'(line_pixels),  858);
      gen_field(525);
      check_val("p_pulses", 32'(pulse_cnt - p0), 1);

      // 526-line field stays inside tolerance
      gen_field(526);
      gen_field(525);
      check_val("tol_mode",   32'(mode),            1);
      check_val("tol_valid",  32'(mode_valid),      1);
      check_val("tol_lines",  32'(field_lines),     526);
      check_val("tol_pulses", 32'(pulse_cnt - p0),  1);

      // freeze counters after a wrap: loss exactly TO clocks later
      counter_x = '0;
      counter_y = '0;
      tick();
      repeat (TO - 1) tick();
      check_val("to_hold_mode",  32'(mode),       1);
      check_val("to_hold_valid", 32'(mode_valid), 1);
      tick();
      check_val("to_mode",    32'(mode),         0);
      check_val("to_valid",   32'(mode_valid),   0);
      check_val("to_changed", 32'(mode_changed), 1);
      check_val("to_lines",   32'(field_lines),  0);
      check_val("to_pixels",  32'(line_pixels),  0);
      tick();
      check_val("to_changed_off", 32'(mode_changed),    0);
      check_val("to_pulses",      32'(pulse_cnt - p0),  2);

      // back in SEARCH: first wrap discarded, relock needs 5 wraps
      repeat (5) gen_field(525);
      check_val("rl_pre_mode", 32'(mode), 0);
      gen_field(525);
      check_val("rl_mode",   32'(mode),       1);
      check_val("rl_valid",  32'(mode_valid), 1);

      // 480i alternation, then 262,262 breaks to 240p
      apply_reset();
      p0 = pulse_cnt;
      gen_field(262); gen_field(263); gen_field(262); gen_field(263); gen_field(262);
      check_val("i_pre_mode", 32'(mode), 0);
      gen_field(262);
      check_val("i_mode",   32'(mode),           3);
      check_val("i_valid",  32'(mode_valid),     1);
      check_val("i_pulses", 32'(pulse_cnt - p0), 1);
      gen_field(262);
      check_val("i_drop_valid", 32'(mode_valid), 0);
      check_val("i_hold_mode",  32'(mode),       3);
      gen_field(262);
      gen_field(262);
      check_val("i_mid_mode",  32'(mode),       3);
      check_val("i_mid_valid", 32'(mode_valid), 0);
      gen_field(262);
      check_val("s_mode",   32'(mode),           2);
      check_val("s_valid",  32'(mode_valid),     1);
      check_val("s_pulses", 32'(pulse_cnt - p0), 2);

      // unknown geometry never locks
      apply_reset();
      p0 = pulse_cnt;
      repeat (6) gen_field(400);
      check_val("u_mode",   32'(mode),           0);
      check_val("u_valid",  32'(mode_valid),     0);
      check_val("u_lines",  32'(field_lines),    0);
      check_val("u_pixels", 32'(line_pixels),    0);
      check_val("u_pulses", 32'(pulse_cnt - p0), 0);

      // 240p lock, reset mid-field, relock
      apply_reset();
      p0 = pulse_cnt;
      repeat (6) gen_field(262);
      check_val("r_lock_mode",  32'(mode),           2);
      check_val("r_lock_valid", 32'(mode_valid),     1);
      check_val("r_lock_lines", 32'(field_lines),    262);
      check_val("r_pulses",     32'(pulse_cnt - p0), 1);
      gen_lines(0, 100, 858);
      reset = 1'b1;
      #1;
      check_val("r_mid_mode",   32'(mode),         0);
      check_val("r_mid_valid",  32'(mode_valid),   0);
      check_val("r_mid_change", 32'(mode_changed), 0);
      check_val("r_mid_lines",  32'(field_lines),  0);
      check_val("r_mid_pixels", 32'(line_pixels),  0);
      tick();
      tick();
      reset = 1'b0;
      gen_lines(100, 262, 858);
      repeat (4) gen_field(262);
      check_val("r_pre_mode", 32'(mode), 0);
      gen_field(262);
      check_val("r_relock_mode",   32'(mode),        2);
      check_val("r_relock_valid",  32'(mode_valid),  1);
      check_val("r_relock_pixels", 32'(line_pixels), 858);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
